// File: rtl/alu_mux.sv
// alu_mux: operand-B source selector for the single-cycle RISC-V ALU.
//
// srcB is a pure combinational mux between the register-file operand and
// the sign-extended immediate. A registered copy of the selected operand
// and select line, and a saturating count of immediate selections, are
// kept alongside for pipeline/debug observation only.
//
// Ports:
//   clk        rising-edge clock (registered outputs only)
//   rst_n      asynchronous active-low reset (registered outputs only)
//   RegOperand rs2 read data
//   ImmExt     sign-extended immediate
//   ALUSrc     source select; only bit 0 matters (1 = immediate)
//   en         capture enable for SrcB_q / SelImm_q / ImmCount
//   SrcB       combinational ALU operand B
//   SrcB_q     SrcB captured when en=1
//   SelImm_q   ALUSrc[0] captured when en=1
//   ImmCount   saturating count of enabled cycles with ALUSrc[0]=1
module alu_mux #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     RegOperand,
  input  logic [WIDTH-1:0]     ImmExt,
  input  logic [31:0]          ALUSrc,
  input  logic                 en,
  output logic [WIDTH-1:0]     SrcB,
  output logic [WIDTH-1:0]     SrcB_q,
  output logic                 SelImm_q,
  output logic [CNT_WIDTH-1:0] ImmCount
);

  logic selImm;
  assign selImm = ALUSrc[0];

  // Upper select bits are architecturally don't-care.
  logic unusedAluSrc;
  assign unusedAluSrc = ^ALUSrc[31:1];

  // Ternary keeps X on the select visible on the output rather than
  // silently defaulting to one source.
  assign SrcB = selImm ? ImmExt : RegOperand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SrcB_q   <= '0;
      SelImm_q <= 1'b0;
    end else if (en) begin
      SrcB_q   <= SrcB;
      SelImm_q <= selImm;
    end
  end

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ImmCount <= '0;
    else if (en && selImm && !(&ImmCount))
      ImmCount <= ImmCount + 1'b1;
  end

endmodule

// File: tb/tb_alu_mux.sv
// tb_alu_mux: self-checking bench for alu_mux. Directed cases plus random
// stimulus against a behavioural model; a second instance with a 4-bit
// counter exercises saturation.
module tb_alu_mux;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  regOp = '0;
  logic [W-1:0]  imm = '0;
  logic [31:0]   aluSrc = '0;
  logic          en = 1'b0;

  logic [W-1:0]  srcB, srcBQ, srcBS, srcBQS;
  logic          selQ, selQS;
  logic [15:0]   cnt;
  logic [3:0]    cntS;

  int errCnt = 0;
  int chkCnt = 0;

  // model state
  logic [W-1:0] mQ;
  logic         mSel;
  int           mCnt, mCntS;

  always #5 clk = ~clk;

  alu_mux #(.WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .RegOperand(regOp), .ImmExt(imm),
    .ALUSrc(aluSrc), .en(en), .SrcB(srcB), .SrcB_q(srcBQ),
    .SelImm_q(selQ), .ImmCount(cnt)
  );

  alu_mux #(.WIDTH(W), .CNT_WIDTH(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .RegOperand(regOp), .ImmExt(imm),
    .ALUSrc(aluSrc), .en(en), .SrcB(srcBS), .SrcB_q(srcBQS),
    .SelImm_q(selQS), .ImmCount(cntS)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] refSel(input logic [W-1:0] r, input logic [W-1:0] i,
                                          input logic [31:0] s);
    return (s % 2 == 1) ? i : r;
  endfunction

  task automatic checkRegs(input string tag);
    chk({tag, ".q"},    srcBQ, mQ);
    chk({tag, ".sel"},  selQ, mSel);
    chk({tag, ".cnt"},  cnt, 64'(mCnt));
    chk({tag, ".cntS"}, cntS, 64'(mCntS));
    chk({tag, ".qS"},   srcBQS, mQ);
  endtask

  // Apply inputs, check comb output, clock once, update model, check regs.
  task automatic cyc(input logic [W-1:0] r, input logic [W-1:0] i,
                     input logic [31:0] s, input logic e, input string tag);
    regOp = r; imm = i; aluSrc = s; en = e;
    #1;
    chk({tag, ".srcB"}, srcB, refSel(r, i, s));
    @(posedge clk);
    if (rst_n && e) begin
      mQ   = refSel(r, i, s);
      mSel = s[0];
      if (s[0]) begin
        mCnt  = (mCnt  < 65535) ? mCnt + 1  : mCnt;
        mCntS = (mCntS < 15)    ? mCntS + 1 : mCntS;
      end
    end
    #1;
    checkRegs(tag);
  endtask

  initial begin
    mQ = '0; mSel = 1'b0; mCnt = 0; mCntS = 0;

    // async reset with no clock edge involved; comb path live during reset
    #2 rst_n = 1'b0;
    regOp = 32'h1234BEEF; imm = 32'h4321FEEB; aluSrc = 32'h0;
    #1;
    checkRegs("rst");
    chk("rst.srcB", srcB, 64'h1234BEEF);
    aluSrc = 32'h1;
    #1 chk("rst.srcBimm", srcB, 64'h4321FEEB);
    // clocks during reset keep registers cleared
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkRegs("rstHold");
    @(negedge clk) rst_n = 1'b1;

    // directed
    cyc(32'h1234BEEF, 32'h4321FEEB, 32'h0,        1'b0, "d0");
    cyc(32'h10001000, 32'h20002000, 32'h1,        1'b1, "d1");
    chk("d1.srcBq", srcBQ, 64'h20002000);
    chk("d1.cnt1",  cnt, 64'd1);
    cyc(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h2,        1'b1, "d2");
    cyc(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b1, "d3");

    // hold with en=0 while inputs move
    for (int k = 0; k < 5; k++)
      cyc($urandom, $urandom, $urandom, 1'b0, "hold");

    // random
    for (int k = 0; k < 300; k++)
      cyc($urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0), "rnd");

    // mid-operation async reset between edges
    @(negedge clk);
    regOp = 32'hCAFE0001; imm = 32'hBEEF0002; aluSrc = 32'h3;
    rst_n = 1'b0;
    mQ = '0; mSel = 1'b0; mCnt = 0; mCntS = 0;
    #1;
    checkRegs("midRst");
    chk("midRst.srcB", srcB, 64'hBEEF0002);
    @(negedge clk) rst_n = 1'b1;

    // saturation of the 4-bit counter over 20 enabled immediate cycles
    for (int k = 0; k < 20; k++)
      cyc($urandom, $urandom, 32'h1, 1'b1, "sat");
    chk("sat.final", cntS, 64'hF);
    chk("sat.cnt20", cnt, 64'd20);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/alu_mux.md
Name: alu_mux

Overview:
- Operand-B source selector for the RISC-V single-cycle datapath ALU.
- Drives ALU input SrcB combinationally, choosing either the register-file read operand (rs2) or the sign-extended immediate (ImmExt) under control of ALUSrc.
- Also provides a registered copy of the selected operand and select, plus a saturating immediate-use counter, for pipeline/debug observation.
- The combinational path is the functional path; the registered outputs are auxiliary.

Parameters:
- WIDTH, 32, data width of RegOperand, ImmExt, SrcB and SrcB_q.
- CNT_WIDTH, 16, width of the immediate-select event counter.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RegOperand  input  WIDTH  register-file operand (rs2 read data).
- ImmExt  input  WIDTH  sign-extended immediate from the extend unit.
- ALUSrc  input  32  source select from the control unit; only bit 0 is significant.
- en  input  1  capture enable for the registered outputs and counter.
- SrcB  output  WIDTH  combinational ALU operand B.
- SrcB_q  output  WIDTH  SrcB registered on clk when en=1.
- SelImm_q  output  1  ALUSrc[0] registered on clk when en=1.
- ImmCount  output  CNT_WIDTH  saturating count of enabled cycles with ALUSrc[0]=1.

Behaviour:
- Combinational path:
  - SrcB = ALUSrc[0] ? ImmExt : RegOperand.
  - Zero latency: SrcB follows input changes within the same delta cycle and has no dependence on clk, rst_n or en.
  - SrcB is valid during reset.
- ALUSrc[31:1] are ignored. ALUSrc=32'h2 selects RegOperand; 32'hFFFFFFFF selects ImmExt.
- X/Z on ALUSrc[0] propagates as X on SrcB. No defaulting.
- Registered path:
  - On rising clk with rst_n=1 and en=1: SrcB_q <= SrcB and SelImm_q <= ALUSrc[0].
  - With en=0: SrcB_q and SelImm_q hold.
- Counter:
  - On rising clk with rst_n=1, en=1 and ALUSrc[0]=1: ImmCount increments by 1.
  - At all-ones it saturates and holds; no wrap.
  - With en=0 or ALUSrc[0]=0: it holds.
- Reset: when rst_n goes low, SrcB_q=0, SelImm_q=0 and ImmCount=0 immediately, without waiting for a clock edge.
  - Registers stay cleared while rst_n=0.
  - The first capture occurs on the first rising clk after rst_n rises.
  - Reset asserted mid-operation discards held values; the combinational SrcB is unaffected.
- Registered output latency is 1 cycle: a value selected in cycle N appears on SrcB_q after edge N.
- No handshake and no state machine.

Test Plan:
- RegOperand=32'h1234BEEF, ImmExt=32'h4321FEEB, ALUSrc=0 -> SrcB=32'h1234BEEF immediately, no clock needed.
- RegOperand=32'h10001000, ImmExt=32'h20002000, ALUSrc=1 -> SrcB=32'h20002000 immediately. With en=1, after the next clk edge: SrcB_q=32'h20002000, SelImm_q=1, ImmCount +1.
- ALUSrc=32'h2 with RegOperand=32'hA5A5A5A5, ImmExt=32'h5A5A5A5A -> SrcB=32'hA5A5A5A5. ALUSrc=32'hFFFFFFFF -> SrcB=32'h5A5A5A5A.
- en=0 over 5 edges while inputs change -> SrcB tracks the inputs; SrcB_q, SelImm_q and ImmCount unchanged.
- After several captures, pulse rst_n low between clock edges -> SrcB_q=0, SelImm_q=0, ImmCount=0 asynchronously, while SrcB still equals the selected input.
- CNT_WIDTH=4, ALUSrc=1, en=1 for 20 cycles -> ImmCount reaches 4'hF and stays at 4'hF.
